// File: rtl/multisim_pkg.sv
// Shared constants and types for the CPU data-stream server side.
// Default sizes for the receive arbiter.
package multisim_pkg;

  localparam int N_CPU_DEF      = 4;
  localparam int DATA_W         = 64;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 32;

  typedef logic [$clog2(N_CPU_DEF)-1:0] cpu_idx_t;
  typedef logic [DATA_W-1:0]            data_t;

endpackage

// File: rtl/cpu_data_rx_arbiter_if.sv
// Per-CPU input streams and merged output stream of the receive arbiter.
// master = stream source/sink side, slave = arbiter side.
interface cpu_data_rx_arbiter_if #(
  parameter int N_CPU  = multisim_pkg::N_CPU_DEF,
  parameter int DATA_W = multisim_pkg::DATA_W,
  parameter int CNT_W  = multisim_pkg::CNT_W_DEF
);
  localparam int IDX_W = $clog2(N_CPU);

  logic [N_CPU-1:0]        in_vld;
  logic [N_CPU-1:0]        in_rdy;
  logic [N_CPU*DATA_W-1:0] in_data;
  logic [N_CPU-1:0]        in_done;
  logic                    out_vld;
  logic                    out_rdy;
  logic [DATA_W-1:0]       out_data;
  logic [IDX_W-1:0]        out_cpu_idx;
  logic [N_CPU*CNT_W-1:0]  xact_cnt;
  logic                    all_done;
  logic                    proto_err;

  modport master (
    output in_vld, in_data, in_done, out_rdy,
    input  in_rdy, out_vld, out_data, out_cpu_idx, xact_cnt, all_done, proto_err
  );

  modport slave (
    input  in_vld, in_data, in_done, out_rdy,
    output in_rdy, out_vld, out_data, out_cpu_idx, xact_cnt, all_done, proto_err
  );

endinterface

// File: rtl/cpu_data_fifo.sv
// Synchronous FIFO; rdata shows the head entry combinationally, push/pop take effect at the edge.
// full depends only on the stored count; push when full and pop when empty are ignored.
module cpu_data_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_data_rx_arbiter.sv
// Per-CPU FIFOs round-robin merged into one registered output tagged with source CPU; 2-cycle push-to-out.
// Output register holds while out_vld && !out_rdy; per-CPU in_rdy is FIFO not-full.
module cpu_data_rx_arbiter #(
  parameter int N_CPU      = multisim_pkg::N_CPU_DEF,
  parameter int DATA_W     = multisim_pkg::DATA_W,
  parameter int FIFO_DEPTH = multisim_pkg::FIFO_DEPTH_DEF,
  parameter int CNT_W      = multisim_pkg::CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  cpu_data_rx_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_CPU);

  logic [N_CPU-1:0]  push, pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata [N_CPU];

  logic              gnt_vld, load_en;
  logic [IDX_W-1:0]  gnt_idx, cand;
  logic [IDX_W-1:0]  rr_q, rr_d;

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;

  logic [CNT_W-1:0]  cnt_q [N_CPU];
  logic [CNT_W-1:0]  cnt_d [N_CPU];
  logic [N_CPU-1:0]  done_q, done_d;
  logic              proto_err_q, proto_err_d;
  logic              all_done_q, all_done_d;

  for (genvar g = 0; g < N_CPU; g++) begin : g_cpu
    cpu_data_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata (bus.in_data[g*DATA_W +: DATA_W]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g]),
      .rdata (fifo_rdata[g])
    );
    assign bus.xact_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign bus.in_rdy      = ~fifo_full;
  assign bus.out_vld     = out_vld_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_cpu_idx = out_idx_q;
  assign bus.all_done    = all_done_q;
  assign bus.proto_err   = proto_err_q;

  // Scan starts one past the last grant so every busy CPU gets a turn.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_CPU; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % N_CPU);
      if (!gnt_vld && !fifo_empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    push       = bus.in_vld & ~fifo_full;
    load_en    = !out_vld_q || bus.out_rdy;
    pop        = '0;
    rr_d       = rr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    if (load_en && gnt_vld) begin
      pop[gnt_idx] = 1'b1;
      rr_d         = gnt_idx;
      out_vld_d    = 1'b1;
      out_data_d   = fifo_rdata[gnt_idx];
      out_idx_d    = gnt_idx;
    end else if (bus.out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CPU; i++) begin
      cnt_d[i] = cnt_q[i];
      if (out_vld_q && bus.out_rdy && out_idx_q == IDX_W'(i) && cnt_q[i] != '1)
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
    done_d = done_q | bus.in_done;
    // done_q is last cycle's view, so a push alongside its own in_done is legal.
    proto_err_d = proto_err_q || |(push & done_q);
    all_done_d  = &done_q && &fifo_empty && !out_vld_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= IDX_W'(N_CPU - 1);
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      done_q      <= '0;
      proto_err_q <= 1'b0;
      all_done_q  <= 1'b0;
      for (int i = 0; i < N_CPU; i++) cnt_q[i] <= '0;
    end else begin
      rr_q        <= rr_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      done_q      <= done_d;
      proto_err_q <= proto_err_d;
      all_done_q  <= all_done_d;
      for (int i = 0; i < N_CPU; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_cpu_data_rx_arbiter.sv
// Directed bench for cpu_data_rx_arbiter: vector table for round-robin merge plus hand-written corner sequences.
module tb_cpu_data_rx_arbiter;
  import multisim_pkg::*;

  localparam int NC = 4;
  localparam int DW = 64;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_data_rx_arbiter_if #(.N_CPU(NC), .DATA_W(DW), .CNT_W(CW)) bus ();

  cpu_data_rx_arbiter #(
    .N_CPU      (NC),
    .DATA_W     (DW),
    .FIFO_DEPTH (4),
    .CNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NC-1:0] vld;
    logic          rdy;
    logic          e_vld;
    int            e_idx;
    int            e_seq;
  } vec_t;

  vec_t tbl [14];

  int          total = 0;
  int          bad   = 0;
  int          pushed [NC];
  int          target [NC];
  logic [NC-1:0] done_drv = '0;

  logic        mon_en    = 1'b0;
  logic        hold_prev = 1'b0;
  logic [65:0] hold_val  = '0;
  logic [65:0] mon_q [$];

  function automatic logic [63:0] word(input int i, input int n);
    return {16'hA5A5, 16'(i), 32'(n)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Records handshakes and checks the output holds while stalled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_prev) begin
        chk("hold_vld", 64'(bus.out_vld), 64'd1);
        chk("hold_data", bus.out_data, hold_val[63:0]);
        chk("hold_idx", 64'(bus.out_cpu_idx), 64'(hold_val[65:64]));
      end
      if (bus.out_vld && bus.out_rdy) mon_q.push_back({bus.out_cpu_idx, bus.out_data});
      hold_prev = bus.out_vld && !bus.out_rdy;
      hold_val  = {bus.out_cpu_idx, bus.out_data};
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    logic [NC-1:0] fire;
    for (int i = 0; i < NC; i++) begin
      bus.in_vld[i] = (pushed[i] < target[i]);
      bus.in_data[i*DW +: DW] = word(i, pushed[i]);
    end
    bus.in_done = done_drv;
    fire = bus.in_vld & bus.in_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) if (fire[i]) pushed[i]++;
    done_drv = '0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NC; i++) begin
      pushed[i] = 0;
      target[i] = 0;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NC; i++) target[i] = pushed[i];
    bus.out_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_vld"}, 64'(bus.out_vld), 64'd0);
    chk({tag, "_out_data"}, bus.out_data, 64'd0);
    chk({tag, "_out_idx"}, 64'(bus.out_cpu_idx), 64'd0);
    chk({tag, "_all_done"}, 64'(bus.all_done), 64'd0);
    chk({tag, "_proto_err"}, 64'(bus.proto_err), 64'd0);
    chk({tag, "_in_rdy"}, 64'(bus.in_rdy), 64'hF);
    for (int i = 0; i < NC; i++) chk({tag, "_xact"}, 64'(bus.xact_cnt[i*CW +: CW]), 64'd0);
  endtask

  task automatic chk_stream(input string tag, input int n, input int first_idx_only);
    chk({tag, "_count"}, 64'(mon_q.size()), 64'(n));
    for (int k = 0; k < mon_q.size() && k < n; k++) begin
      if (first_idx_only != 0) begin
        chk({tag, "_idx"}, 64'(mon_q[k][65:64]), 64'd0);
        chk({tag, "_data"}, mon_q[k][63:0], word(0, k));
      end else begin
        chk({tag, "_idx"}, 64'(mon_q[k][65:64]), 64'(k % NC));
        chk({tag, "_data"}, mon_q[k][63:0], word(k % NC, k / NC));
      end
    end
  endtask

  initial begin
    int n;
    logic tog;

    // All four CPUs push three words back to back, sink always ready.
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 0, 0};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 0, 0};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 1, 0};
    tbl[3]  = '{4'h0, 1'b1, 1'b1, 2, 0};
    tbl[4]  = '{4'h0, 1'b1, 1'b1, 3, 0};
    tbl[5]  = '{4'h0, 1'b1, 1'b1, 0, 1};
    tbl[6]  = '{4'h0, 1'b1, 1'b1, 1, 1};
    tbl[7]  = '{4'h0, 1'b1, 1'b1, 2, 1};
    tbl[8]  = '{4'h0, 1'b1, 1'b1, 3, 1};
    tbl[9]  = '{4'h0, 1'b1, 1'b1, 0, 2};
    tbl[10] = '{4'h0, 1'b1, 1'b1, 1, 2};
    tbl[11] = '{4'h0, 1'b1, 1'b1, 2, 2};
    tbl[12] = '{4'h0, 1'b1, 1'b1, 3, 2};
    tbl[13] = '{4'h0, 1'b1, 1'b0, 0, 0};

    bus.in_vld  = '0;
    bus.in_data = '0;
    bus.in_done = '0;
    bus.out_rdy = 1'b0;
    clear_counts();

    do_reset();
    chk_reset_state("rst");

    // Single word on CPU 2.
    bus.out_rdy = 1'b1;
    bus.in_vld  = 4'b0100;
    bus.in_data[2*DW +: DW] = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    bus.in_vld = '0;
    chk("single_t1_vld", 64'(bus.out_vld), 64'd0);
    @(posedge clk); #1;
    chk("single_vld", 64'(bus.out_vld), 64'd1);
    chk("single_idx", 64'(bus.out_cpu_idx), 64'd2);
    chk("single_data", bus.out_data, 64'hDEAD_BEEF_0000_0001);
    chk("single_cnt_pre", 64'(bus.xact_cnt[2*CW +: CW]), 64'd0);
    @(posedge clk); #1;
    chk("single_cnt", 64'(bus.xact_cnt[2*CW +: CW]), 64'd1);
    chk("single_vld_off", 64'(bus.out_vld), 64'd0);

    // Round-robin vector table from a fresh pointer.
    do_reset();
    clear_counts();
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < NC; i++) target[i] = pushed[i] + int'(tbl[r].vld[i]);
      bus.out_rdy = tbl[r].rdy;
      tick();
      chk($sformatf("tbl%0d_vld", r), 64'(bus.out_vld), 64'(tbl[r].e_vld));
      chk($sformatf("tbl%0d_in_rdy", r), 64'(bus.in_rdy), 64'hF);
      if (tbl[r].e_vld) begin
        chk($sformatf("tbl%0d_idx", r), 64'(bus.out_cpu_idx), 64'(tbl[r].e_idx));
        chk($sformatf("tbl%0d_data", r), bus.out_data, word(tbl[r].e_idx, tbl[r].e_seq));
      end
    end
    for (int i = 0; i < NC; i++) chk($sformatf("tbl_xact%0d", i), 64'(bus.xact_cnt[i*CW +: CW]), 64'd3);

    // Backpressure: CPU 0 offers 6 words with the sink stalled.
    do_reset();
    clear_counts();
    mon_q.delete();
    mon_en = 1'b1;
    target[0] = 6;
    for (int c = 0; c < 8; c++) tick();
    chk("bp_accepted", 64'(pushed[0]), 64'd5);
    chk("bp_in_rdy0", 64'(bus.in_rdy[0]), 64'd0);
    chk("bp_none_out", 64'(mon_q.size()), 64'd0);
    bus.out_rdy = 1'b1;
    n = 0;
    while (mon_q.size() < 6 && n < 40) begin tick(); n++; end
    chk_stream("bp", 6, 1);
    tick();
    chk("bp_idle", 64'(bus.out_vld), 64'd0);
    chk("bp_xact0", 64'(bus.xact_cnt[0 +: CW]), 64'd6);
    mon_en = 1'b0;

    // Sink ready toggles every cycle.
    do_reset();
    clear_counts();
    mon_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < NC; i++) target[i] = 2;
    tog = 1'b1;
    n = 0;
    while (mon_q.size() < 8 && n < 60) begin
      bus.out_rdy = tog;
      tog = ~tog;
      tick();
      n++;
    end
    chk_stream("tog", 8, 0);
    bus.out_rdy = 1'b1;
    tick(); tick();
    chk("tog_no_dup", 64'(mon_q.size()), 64'd8);
    mon_en = 1'b0;

    // End-of-stream on all CPUs while data still buffered.
    do_reset();
    clear_counts();
    mon_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < NC; i++) target[i] = 2;
    tick();
    done_drv = 4'hF;
    tick();
    chk("done_same_cycle_perr", 64'(bus.proto_err), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("done_stalled", 64'(bus.all_done), 64'd0);
    end
    bus.out_rdy = 1'b1;
    n = 0;
    while (mon_q.size() < 8 && n < 40) begin
      tick();
      chk("done_early", 64'(bus.all_done), 64'd0);
      n++;
    end
    chk_stream("done", 8, 0);
    chk("done_out_idle", 64'(bus.out_vld), 64'd0);
    tick();
    chk("done_rise", 64'(bus.all_done), 64'd1);
    chk("done_perr", 64'(bus.proto_err), 64'd0);
    mon_en = 1'b0;

    // Push on CPU 1 two cycles after its in_done.
    do_reset();
    clear_counts();
    mon_q.delete();
    mon_en = 1'b1;
    bus.out_rdy = 1'b1;
    done_drv = 4'b0010;
    tick();
    chk("perr_after_done", 64'(bus.proto_err), 64'd0);
    tick();
    chk("perr_idle", 64'(bus.proto_err), 64'd0);
    target[1] = 1;
    tick();
    chk("perr_set", 64'(bus.proto_err), 64'd1);
    tick(); tick();
    chk("perr_word_cnt", 64'(mon_q.size()), 64'd1);
    if (mon_q.size() > 0) begin
      chk("perr_word_idx", 64'(mon_q[0][65:64]), 64'd1);
      chk("perr_word_data", mon_q[0][63:0], word(1, 0));
    end
    chk("perr_sticky", 64'(bus.proto_err), 64'd1);
    mon_en = 1'b0;

    // Reset with words buffered and the output stalled.
    bus.out_rdy = 1'b0;
    for (int i = 0; i < NC; i++) target[i] = pushed[i] + 3;
    tick(); tick(); tick();
    chk("mid_pre_vld", 64'(bus.out_vld), 64'd1);
    do_reset();
    chk_reset_state("mid");
    bus.out_rdy = 1'b1;
    tick(); tick();
    chk("mid_no_flush", 64'(bus.out_vld), 64'd0);
    chk("mid_in_rdy", 64'(bus.in_rdy), 64'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
